// File: rtl/kypd_entry_ctrl.sv
// kypd_entry_ctrl: scans a 4x4 PmodKYPD keypad, debounces whole scan frames,
// decodes one key per press and keeps a 3-digit BCD entry history plus the
// record-mode flag for the seven-segment display controller.
module kypd_entry_ctrl #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic [3:0] disp_val,
  output logic [3:0] disp_val2,
  output logic [3:0] disp_val3,
  output logic       is_record
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_TARGET = DW'(DEBOUNCE_SCANS);

  typedef enum logic {
    S_IDLE,
    S_PRESSED
  } state_t;

  // Key legend indexed by (row, column) of the physical keypad.
  function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  logic [3:0]    row_s1_q, row_s2_q;
  logic [SW-1:0] scan_cnt_q;
  logic [1:0]    col_idx_q;
  logic [1:0]    hit_cnt_q, hit_cnt_d;
  logic [3:0]    hit_key_q, hit_key_d;

  state_t        state_q, state_d;
  logic [DW-1:0] stable_cnt_q, stable_cnt_d;
  logic [DW-1:0] rel_cnt_q, rel_cnt_d;
  logic          prev_valid_q, prev_valid_d;
  logic [3:0]    prev_key_q, prev_key_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          strobe_q, strobe_d;
  logic [3:0]    dig0_q, dig0_d, dig1_q, dig1_d, dig2_q, dig2_d;
  logic          rec_q, rec_d;

  logic          sample_now, frame_end;
  logic [2:0]    col_hits, frame_hits;
  logic [1:0]    col_row;
  logic [3:0]    cur_key;
  logic          res_valid;
  logic [3:0]    res_key;

  // Two-flop synchroniser for the asynchronous, active-low row lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
    end
  end

  assign sample_now = (scan_cnt_q == SCAN_LAST);
  assign frame_end  = sample_now && (col_idx_q == 2'd3);
  assign col        = ~(4'b0001 << col_idx_q);

  // Column dwell counter; the driven column advances after each row sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      col_idx_q  <= 2'd0;
    end else if (sample_now) begin
      scan_cnt_q <= '0;
      col_idx_q  <= col_idx_q + 2'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  // Count low rows in the current column and locate the last one seen.
  always_comb begin
    col_hits = 3'd0;
    col_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2_q[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
    cur_key    = key_lut(col_row, col_idx_q);
    frame_hits = {1'b0, hit_cnt_q} + col_hits;
    res_valid  = (frame_hits == 3'd1);
    res_key    = (col_hits == 3'd1) ? cur_key : hit_key_q;
    hit_cnt_d  = hit_cnt_q;
    hit_key_d  = hit_key_q;
    if (frame_end) begin
      hit_cnt_d = 2'd0;
      hit_key_d = 4'h0;
    end else if (sample_now) begin
      hit_cnt_d = (frame_hits >= 3'd2) ? 2'd2 : frame_hits[1:0];
      if (col_hits == 3'd1) hit_key_d = cur_key;
    end
  end

  // Per-frame accumulator of row-low hits (saturates at "ambiguous").
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= 2'd0;
      hit_key_q <= 4'h0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      hit_key_q <= hit_key_d;
    end
  end

  // Debounce next-state and accept action, evaluated only at frame end.
  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    rel_cnt_d    = rel_cnt_q;
    prev_valid_d = prev_valid_q;
    prev_key_d   = prev_key_q;
    key_code_d   = key_code_q;
    strobe_d     = 1'b0;
    dig0_d       = dig0_q;
    dig1_d       = dig1_q;
    dig2_d       = dig2_q;
    rec_d        = rec_q;
    if (frame_end) begin
      prev_valid_d = res_valid;
      prev_key_d   = res_key;
      case (state_q)
        S_IDLE: begin
          if (res_valid) begin
            if (prev_valid_q && (prev_key_q == res_key)) stable_cnt_d = stable_cnt_q + 1'b1;
            else                                         stable_cnt_d = DW'(1);
            if (stable_cnt_d == DEB_TARGET) begin
              state_d      = S_PRESSED;
              stable_cnt_d = '0;
              rel_cnt_d    = '0;
              strobe_d     = 1'b1;
              key_code_d   = res_key;
              if (res_key <= 4'd9) begin
                dig2_d = dig1_q;
                dig1_d = dig0_q;
                dig0_d = res_key;
              end else if (res_key == 4'hC) begin
                dig0_d = 4'd0;
                dig1_d = 4'd0;
                dig2_d = 4'd0;
              end else if (res_key == 4'hF) begin
                rec_d = ~rec_q;
              end
            end
          end else begin
            stable_cnt_d = '0;
          end
        end
        default: begin
          if (!res_valid) begin
            rel_cnt_d = rel_cnt_q + 1'b1;
            if (rel_cnt_d == DEB_TARGET) begin
              state_d   = S_IDLE;
              rel_cnt_d = '0;
            end
          end else begin
            rel_cnt_d = '0;
          end
        end
      endcase
    end
  end

  // Debounce state and entry-history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      stable_cnt_q <= '0;
      rel_cnt_q    <= '0;
      prev_valid_q <= 1'b0;
      prev_key_q   <= 4'h0;
      key_code_q   <= 4'h0;
      strobe_q     <= 1'b0;
      dig0_q       <= 4'h0;
      dig1_q       <= 4'h0;
      dig2_q       <= 4'h0;
      rec_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
      prev_valid_q <= prev_valid_d;
      prev_key_q   <= prev_key_d;
      key_code_q   <= key_code_d;
      strobe_q     <= strobe_d;
      dig0_q       <= dig0_d;
      dig1_q       <= dig1_d;
      dig2_q       <= dig2_d;
      rec_q        <= rec_d;
    end
  end

  assign key_code   = key_code_q;
  assign key_strobe = strobe_q;
  assign disp_val   = dig0_q;
  assign disp_val2  = dig1_q;
  assign disp_val3  = dig2_q;
  assign is_record  = rec_q;

endmodule

// File: tb/tb_kypd_entry_ctrl.sv
// Testbench for kypd_entry_ctrl: a keypad model drives the rows from the
// column drive; a frame-level reference model predicts every output.
module tb_kypd_entry_ctrl;

  localparam int SD = 8;
  localparam int DB = 2;
  localparam int FRAME = 4 * SD;
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row, col, key_code, disp_val, disp_val2, disp_val3;
  logic       key_strobe, is_record;
  logic [15:0] mask = 16'h0;

  int vectors = 0;
  int errors = 0;
  int strobe_seen = 0;

  // reference model state
  int   m_state, m_stable, m_rel, m_prev_key;
  bit   m_prev_valid, m_rec;
  logic [3:0] m_code, m_d1, m_d2, m_d3;

  always #5 clk = ~clk;

  // Keypad: a pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  kypd_entry_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
    .key_strobe(key_strobe), .disp_val(disp_val), .disp_val2(disp_val2),
    .disp_val3(disp_val3), .is_record(is_record));

  function automatic logic [15:0] key_mask(input logic [3:0] k);
    logic [15:0] m = 16'h0;
    for (int i = 0; i < 16; i++) if (KEYMAP[i] == k) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_state = 0; m_stable = 0; m_rel = 0; m_prev_key = 0; m_prev_valid = 0;
    m_rec = 0; m_code = 0; m_d1 = 0; m_d2 = 0; m_d3 = 0;
  endtask

  // One whole frame with a fixed set of held keys.
  task automatic model_frame(input logic [15:0] msk, output bit acc);
    bit v;
    int k;
    v = ($countones(msk) == 1);
    k = 0;
    for (int i = 0; i < 16; i++) if (msk[i]) k = int'(KEYMAP[i]);
    acc = 0;
    if (m_state == 0) begin
      if (v) begin
        m_stable = (m_prev_valid && m_prev_key == k) ? m_stable + 1 : 1;
        if (m_stable == DB) begin
          acc = 1; m_state = 1; m_stable = 0; m_rel = 0;
        end
      end else m_stable = 0;
    end else begin
      if (!v) begin
        m_rel++;
        if (m_rel == DB) begin m_state = 0; m_rel = 0; end
      end else m_rel = 0;
    end
    m_prev_valid = v;
    m_prev_key = k;
    if (acc) begin
      m_code = 4'(k);
      if (k <= 9) begin m_d3 = m_d2; m_d2 = m_d1; m_d1 = 4'(k); end
      else if (k == 12) begin m_d1 = 0; m_d2 = 0; m_d3 = 0; end
      else if (k == 15) m_rec = ~m_rec;
    end
  endtask

  // Hold msk for one frame, checking col, strobe and outputs every cycle.
  task automatic run_frame(input logic [15:0] msk);
    logic [16:0] old_outs, new_outs, exp_outs, got_outs;
    logic [3:0] exp_col;
    bit acc;
    mask = msk;
    old_outs = {m_code, m_d1, m_d2, m_d3, m_rec};
    model_frame(msk, acc);
    new_outs = {m_code, m_d1, m_d2, m_d3, m_rec};
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk); #1;
      exp_col = ~(4'b0001 << ((i / SD) % 4));
      exp_outs = (i == FRAME) ? new_outs : old_outs;
      got_outs = {key_code, disp_val, disp_val2, disp_val3, is_record};
      vectors += 3;
      if (col !== exp_col) begin
        errors++; $display("FAIL col cyc%0d: got %b want %b", i, col, exp_col);
      end
      if (key_strobe !== (i == FRAME && acc)) begin
        errors++; $display("FAIL strobe cyc%0d mask=%h: got %b want %b", i, msk, key_strobe, (i == FRAME && acc));
      end
      if (got_outs !== exp_outs) begin
        errors++; $display("FAIL outs cyc%0d {code,d1,d2,d3,rec}: got %h want %h", i, got_outs, exp_outs);
      end
      if (key_strobe === 1'b1) strobe_seen++;
    end
    if (acc) $display("frame mask=%h -> accept key %h", msk, new_outs[16:13]);
  endtask

  task automatic hold(input logic [15:0] msk, input int n);
    for (int i = 0; i < n; i++) run_frame(msk);
  endtask

  task automatic press(input logic [3:0] k);
    hold(key_mask(k), 4);
    hold(16'h0, 4);
  endtask

  task automatic test_reset();
    rst = 1'b1; mask = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    vectors += 2;
    if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", col); end
    if ({key_code, key_strobe, disp_val, disp_val2, disp_val3, is_record} !== 18'h0) begin
      errors++; $display("FAIL reset_outs: got %h want 0",
        {key_code, key_strobe, disp_val, disp_val2, disp_val3, is_record});
    end
    rst = 1'b0;
    model_reset();
    hold(16'h0, 1);
    $display("test_reset done");
  endtask

  task automatic test_single_press();
    int s0 = strobe_seen;
    hold(key_mask(4'h5), 4);
    hold(16'h0, 3);
    vectors++;
    if ({strobe_seen - s0 == 1, key_code, disp_val, disp_val2, disp_val3} !== {1'b1, 16'h5500}) begin
      errors++; $display("FAIL single_press: strobes=%0d code=%h digits=%h%h%h want 1,5,500",
        strobe_seen - s0, key_code, disp_val, disp_val2, disp_val3);
    end
    $display("test_single_press done");
  endtask

  task automatic test_history();
    press(4'h1); press(4'h2); press(4'h3);
    vectors++;
    if ({disp_val, disp_val2, disp_val3} !== 12'h321) begin
      errors++; $display("FAIL history_123: got %h%h%h want 321", disp_val, disp_val2, disp_val3);
    end
    press(4'h4);
    vectors++;
    if ({disp_val, disp_val2, disp_val3} !== 12'h432) begin
      errors++; $display("FAIL history_4: got %h%h%h want 432", disp_val, disp_val2, disp_val3);
    end
    $display("test_history done");
  endtask

  task automatic test_bounce();
    int s0 = strobe_seen;
    hold(key_mask(4'h7), 1);
    hold(16'h0, 3);
    vectors++;
    if (strobe_seen != s0 || disp_val !== 4'h4) begin
      errors++; $display("FAIL bounce_short: strobes=%0d d1=%h want 0,4", strobe_seen - s0, disp_val);
    end
    s0 = strobe_seen;
    hold(key_mask(4'h5), 3);
    hold(16'h0, 1);
    hold(key_mask(4'h5), 3);
    hold(16'h0, 3);
    vectors++;
    if (strobe_seen - s0 != 1) begin
      errors++; $display("FAIL bounce_glitch: strobes=%0d want 1", strobe_seen - s0);
    end
    $display("test_bounce done");
  endtask

  task automatic test_mode_keys();
    int s0;
    press(4'hF);
    vectors++;
    if (is_record !== 1'b1) begin errors++; $display("FAIL rec_on: got %b want 1", is_record); end
    press(4'h9); press(4'h8); press(4'h7); press(4'hC);
    vectors++;
    if ({key_code, disp_val, disp_val2, disp_val3, is_record} !== {16'hC000, 1'b1}) begin
      errors++; $display("FAIL clear: got code=%h digits=%h%h%h rec=%b want C,000,1",
        key_code, disp_val, disp_val2, disp_val3, is_record);
    end
    press(4'hF);
    vectors++;
    if (is_record !== 1'b0) begin errors++; $display("FAIL rec_off: got %b want 0", is_record); end
    press(4'h6);
    s0 = strobe_seen;
    press(4'hA);
    vectors++;
    if ({strobe_seen - s0 == 1, key_code, disp_val, disp_val2, disp_val3} !== {1'b1, 16'hA600}) begin
      errors++; $display("FAIL key_A: strobes=%0d code=%h digits=%h%h%h want 1,A,600",
        strobe_seen - s0, key_code, disp_val, disp_val2, disp_val3);
    end
    $display("test_mode_keys done");
  endtask

  task automatic test_ambiguity();
    int s0 = strobe_seen;
    hold(key_mask(4'h1) | key_mask(4'h6), 5);
    hold(16'h0, 3);
    vectors++;
    if (strobe_seen != s0) begin
      errors++; $display("FAIL ambiguous: strobes=%0d want 0", strobe_seen - s0);
    end
    $display("test_ambiguity done");
  endtask

  task automatic test_reset_midpress();
    int s0;
    mask = key_mask(4'h2);
    repeat (13) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    vectors++;
    if ({col, key_code, key_strobe, disp_val, disp_val2, disp_val3, is_record} !== {4'b1110, 18'h0}) begin
      errors++; $display("FAIL midreset: col=%b outs=%h want 1110,0", col,
        {key_code, key_strobe, disp_val, disp_val2, disp_val3, is_record});
    end
    s0 = strobe_seen;
    hold(key_mask(4'h2), 3);
    vectors++;
    if (strobe_seen - s0 != 1 || key_code !== 4'h2) begin
      errors++; $display("FAIL midreset_press: strobes=%0d code=%h want 1,2", strobe_seen - s0, key_code);
    end
    hold(16'h0, 3);
    $display("test_reset_midpress done");
  endtask

  task automatic test_random();
    logic [15:0] m;
    int sel;
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      else if (sel == 1) m = 16'h0;
      else m = 16'h1 << $urandom_range(0, 15);
      hold(m, $urandom_range(1, 5));
    end
    hold(16'h0, 3);
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_history();
    test_bounce();
    test_mode_keys();
    test_ambiguity();
    test_reset_midpress();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kypd_entry_ctrl.md
Name: kypd_entry_ctrl

Overview:
- Upstream feeder for the seven-segment display controller.
- Scans the PmodKYPD 4x4 keypad, synchronises and debounces the rows, and decodes one key per press.
- Maintains a 3-digit BCD entry history (DispVal, DispVal2, DispVal3) and the isRecord flag consumed by the display controller.

Parameters:
- SCAN_DIV, 100000: clk cycles each column is driven (1 ms at 100 MHz); must be ≥ 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release; ≥ 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- row  in  4  keypad rows, active-low, asynchronous; row[0] = top row
- col  out  4  keypad columns, one-hot-low drive; col[0] = leftmost column
- key_code  out  4  hex value of the last accepted key
- key_strobe  out  1  one-cycle pulse per accepted press
- disp_val  out  4  newest digit → DispVal
- disp_val2  out  4  previous digit → DispVal2
- disp_val3  out  4  oldest digit → DispVal3
- is_record  out  1  record mode flag → isRecord

Behaviour:
- Reset values: col=4'b1110, key_code=0, key_strobe=0, disp_val/2/3=0, is_record=0. All counters, the synchroniser and debounce state are cleared. Reset mid-press discards any partial scan.
- Key map, rows top to bottom:
  - 1 2 3 A
  - 4 5 6 B
  - 7 8 9 C
  - 0 F E D
  - Column c, row r indexes this map.
- Row input passes through a 2-flop synchroniser before use.
- Scan counter runs 0..SCAN_DIV-1 per column. Rows are sampled at count SCAN_DIV-1, then col rotates 1110→1101→1011→0111→1110.
- One frame = 4 columns = 4*SCAN_DIV cycles. At the end of the frame, the scan result is:
  - NONE if no row was low in any column;
  - KEY(k) if exactly one row-low was seen in the whole frame;
  - NONE if two or more row-lows were seen (multi-key is ambiguous).
- Debounce FSM, evaluated once per frame end:
  - IDLE: KEY(k) equal to the previous frame's result increments stable_cnt, otherwise stable_cnt=1 (tracks k). On stable_cnt reaching DEBOUNCE_SCANS → PRESSED, fire the accept action.
  - PRESSED: NONE for DEBOUNCE_SCANS consecutive frames → IDLE. Any other result resets the release count. A different key while in PRESSED is ignored until release.
- Accept action, all on the same clock edge, visible the cycle after the frame-end edge:
  - key_strobe=1 for exactly 1 cycle; key_code=k.
  - k in 0..9: disp_val3←disp_val2, disp_val2←disp_val, disp_val←k. The oldest digit is dropped.
  - k=C: disp_val/2/3←0; is_record unchanged.
  - k=F: is_record toggles.
  - k in A, B, D, E: strobe and key_code only; no other effect.
- Latency from a stable press to strobe is DEBOUNCE_SCANS frames, plus up to 1 frame of alignment, plus 3 cycles.
- Digit outputs are always 0..9. No other output changes except on the accept action or reset.

Test Plan:
- Bench uses SCAN_DIV=8, DEBOUNCE_SCANS=2 (frame = 32 cycles).
- Reset:
  - Assert rst for 3 cycles, rows all 1 → col=1110 and all outputs 0 immediately after reset.
  - col=1101 after 8 cycles; returns to 1110 after 32 cycles.
- Single press:
  - Drive row[1] low whenever col[1]=0 (key 5), held for 4 frames → exactly one key_strobe, key_code=5, disp_val=5, disp_val2=0, disp_val3=0.
- History shift:
  - Press/release 1, 2, 3, each held 4 frames with 4 idle frames between → disp_val=3, disp_val2=2, disp_val3=1.
  - Then key 4 → 4, 3, 2.
- Bounce rejection:
  - Key 7 held for 1 frame only, then released → no strobe, outputs unchanged.
  - Release glitch of 1 frame mid-hold → no second strobe.
- Mode keys:
  - F → is_record 0→1; F again → 0.
  - With digits 9, 8, 7 loaded, C → all digits 0, is_record unchanged, key_code=C.
  - A → strobe, key_code=A, digits unchanged.
- Ambiguity and reset:
  - Keys 1 and 6 held together for 5 frames → no strobe.
  - Key 2 held, rst pulsed mid-frame → outputs cleared and col=1110; with key 2 still held, strobe with key_code=2 after 2 to 3 frames.
